lut_layer_scheduler: RTL and testbench
======================================

# lut_layer_scheduler

Time-multiplexed evaluator for one LogicNet layer: a single shared 6-input/2-output LUT datapath is sequenced across all neurons of the layer, one neuron per clock. Each neuron's truth table and fan-in selection are runtime-programmable, so one instance replaces N_NEURONS hard-wired neuron ROMs when area matters more than throughput. It sits between the feature quantiser (upstream valid/ready) and the next layer or classifier (downstream valid/ready).

## Interface
- IN_FEATURES, 16, number of 2-bit input features
- N_NEURONS, 8, neurons evaluated per input vector
- FAN_IN, 3, inputs per neuron (fixed: FAN_IN*2 = 6 LUT address bits)
- SW, $clog2(IN_FEATURES) = 4, feature-select index width
- NW, $clog2(N_NEURONS) = 3, neuron index width

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  scheduler can accept a vector
- in_data  in  IN_FEATURES*2  feature f at bits [2f+1:2f]
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts result
- out_data  out  N_NEURONS*2  neuron n result at bits [2n+1:2n]
- cfg_ready  out  1  config writes accepted this cycle
- lut_we  in  1  truth-table write strobe
- lut_addr  in  NW+6  {neuron, 6-bit entry}
- lut_data  in  2  entry value
- map_we  in  1  fan-in map write strobe
- map_addr  in  NW  neuron index
- map_data  in  FAN_IN*SW  {sel2, sel1, sel0}, sel0 in LSBs
- busy  out  1  high in EVAL or OUT

## Operation
- Storage: truth table N_NEURONS×64×2 bits; fan-in map N_NEURONS×(FAN_IN*SW) bits; captured input register; result register.
- FSM states IDLE, EVAL, OUT. Reset state IDLE.
- IDLE: in_ready=1, cfg_ready=1. On in_valid&in_ready: capture in_data, clear neuron counter k to 0, go EVAL.
- EVAL: per cycle, address = {x[sel2], x[sel1], x[sel0]} for neuron k (x = captured features, sel0 bits in address[1:0]); result[k] <= table[k][address]; k increments. After k = N_NEURONS-1, go OUT. Counter does not wrap past N_NEURONS-1.
- OUT: out_valid=1, out_data = result register, held stable until out_ready; on out_valid&out_ready go IDLE.
- Config writes take effect only when cfg_ready=1 (IDLE); strobes in EVAL/OUT are ignored, no error, no queuing. lut_we and map_we in the same cycle both commit.
- Config write and input handshake in the same IDLE cycle: both commit; the accepted vector is evaluated with the new values.
- map sel values ≥ IN_FEATURES (non-power-of-two configs): selected feature reads as 2'b00.
- lut_addr neuron field ≥ N_NEURONS: write ignored.

## Timing
- Reset (async assert, any state): state IDLE, k=0, out_valid=0, out_data=0, busy=0, in_ready=1, cfg_ready=1, truth table and map cleared to 0. In-flight vector discarded.
- Latency: handshake in cycle c0; neurons evaluated in c1..cN; out_valid first high in cycle cN+1 (N_NEURONS+1 cycles after accept).
- in_ready is low from c1 until the cycle after the output handshake; it is never high while out_valid is high.
- Max throughput with out_ready held 1 and in_valid held 1: one vector per N_NEURONS+2 cycles.
- in_ready, cfg_ready, out_valid, busy decode from registered state only; no combinational path from in_valid/out_ready to any ready/valid output.
- out_data changes only on the final EVAL cycle's update; stable throughout OUT under backpressure.

## Test plan
- Reset then vector in_data=32'hFFFF_FFFF, out_ready=1 -> out_valid at c9, out_data=16'h0000; in_ready returns high at c10.
- Write map[3]={7,4,0}, lut[{3,6'b110101}]=2'b11; send f0=2'b01, f4=2'b01, f7=2'b11, rest 0 -> out_data=16'h00C0.
- Same vector, out_ready low 5 cycles in OUT -> out_data held at 16'h00C0, in_ready=0, second in_valid not accepted until cycle after handshake.
- lut_we to {3,6'b110101} with data 2'b00 during EVAL -> cfg_ready=0, write dropped; repeated vector still gives 16'h00C0.
- Assert rst_n low during EVAL at k=4 -> out_valid=0, busy=0, in_ready=1 immediately; after release, prior vector gives 16'h0000 (tables cleared).
- in_valid and out_ready held 1 for 100 cycles -> accepts every 10 cycles, 10 results, none dropped or duplicated.

Source files
------------

// File: rtl/lut_layer_scheduler.sv
// Time-multiplexed LogicNet layer: one shared 6-in/2-out LUT datapath evaluates
// every neuron of the layer in turn, with runtime-programmable tables and fan-in maps.
module lut_layer_scheduler #(
  parameter int IN_FEATURES = 16,
  parameter int N_NEURONS   = 8,
  parameter int FAN_IN      = 3,
  parameter int SW          = $clog2(IN_FEATURES),
  parameter int NW          = $clog2(N_NEURONS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_FEATURES*2-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_NEURONS*2-1:0]     out_data,
  output logic                       cfg_ready,
  input  logic                       lut_we,
  input  logic [NW+2*FAN_IN-1:0]     lut_addr,
  input  logic [1:0]                 lut_data,
  input  logic                       map_we,
  input  logic [NW-1:0]              map_addr,
  input  logic [FAN_IN*SW-1:0]       map_data,
  output logic                       busy,
  output logic [1:0]                 dbg_state
);

  localparam int AW      = 2 * FAN_IN;
  localparam int ENTRIES = 2 ** AW;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready/valid outputs decode from the state register only.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [NW-1:0]            k_q, k_d;
  logic [IN_FEATURES*2-1:0] x_q, x_d;
  logic [N_NEURONS*2-1:0]   result_q, result_d;
  logic [N_NEURONS*2-1:0]   out_q, out_d;
  logic [1:0]               table_q [N_NEURONS][ENTRIES];
  logic [1:0]               table_d [N_NEURONS][ENTRIES];
  logic [FAN_IN*SW-1:0]     map_q [N_NEURONS];
  logic [FAN_IN*SW-1:0]     map_d [N_NEURONS];

  logic [NW-1:0]            lut_n;
  logic [AW-1:0]            lut_e;
  logic [AW-1:0]            lut_index;
  logic [1:0]               lut_value;

  // Out-of-range selects (non-power-of-two feature counts) read as zero.
  function automatic logic [1:0] feat(input logic [SW-1:0] s,
                                      input logic [IN_FEATURES*2-1:0] x);
    logic [1:0] r;
    r = '0;
    for (int f = 0; f < IN_FEATURES; f++) begin
      if (32'(s) == f) r = x[2*f +: 2];
    end
    return r;
  endfunction

  assign lut_n = lut_addr[NW+AW-1:AW];
  assign lut_e = lut_addr[AW-1:0];

  always_comb begin
    lut_index = '0;
    for (int j = 0; j < FAN_IN; j++) begin
      lut_index[2*j +: 2] = feat(map_q[k_q][SW*j +: SW], x_q);
    end
    lut_value = table_q[k_q][lut_index];
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    x_d      = x_q;
    result_d = result_q;
    out_d    = out_q;
    table_d  = table_q;
    map_d    = map_q;

    // Config only lands while idle; a same-cycle input accept sees the new values
    // because evaluation starts on the following cycle.
    if (state_q == S_IDLE) begin
      if (lut_we && (32'(lut_n) < N_NEURONS)) table_d[lut_n][lut_e] = lut_data;
      if (map_we && (32'(map_addr) < N_NEURONS)) map_d[map_addr] = map_data;
    end

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = in_data;
          k_d     = '0;
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        for (int n = 0; n < N_NEURONS; n++) begin
          if (32'(k_q) == n) result_d[2*n +: 2] = lut_value;
        end
        if (32'(k_q) == N_NEURONS - 1) begin
          out_d   = result_d;
          state_d = S_OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      x_q      <= '0;
      result_q <= '0;
      out_q    <= '0;
      table_q  <= '{default: '0};
      map_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      x_q      <= x_d;
      result_q <= result_d;
      out_q    <= out_d;
      table_q  <= table_d;
      map_q    <= map_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign cfg_ready = (state_q == S_IDLE);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lut_layer_scheduler.sv
// Bench for lut_layer_scheduler: scenario tasks checked against a table/map
// reference model evaluated directly from the layer's lookup rules.
module tb_lut_layer_scheduler;

  localparam int IN_FEATURES = 16;
  localparam int N_NEURONS   = 8;
  localparam int LAT         = N_NEURONS + 1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        cfg_ready;
  logic        lut_we;
  logic [8:0]  lut_addr;
  logic [1:0]  lut_data;
  logic        map_we;
  logic [2:0]  map_addr;
  logic [11:0] map_data;
  logic        busy;
  logic [1:0]  dbg_state;

  int vectors;
  int miscompares;

  logic [1:0]  model_lut [N_NEURONS][64];
  logic [11:0] model_map [N_NEURONS];
  logic [15:0] exp_q [$];

  lut_layer_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .cfg_ready(cfg_ready),
    .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data),
    .map_we(map_we), .map_addr(map_addr), .map_data(map_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic model_clear;
    for (int n = 0; n < N_NEURONS; n++) begin
      model_map[n] = '0;
      for (int e = 0; e < 64; e++) model_lut[n][e] = 2'b00;
    end
  endtask

  function automatic int model_addr(input int n, input logic [31:0] x);
    int a;
    int sel;
    a = 0;
    for (int j = 0; j < 3; j++) begin
      sel = int'(model_map[n][4*j +: 4]);
      if (sel < IN_FEATURES) a += int'(x[2*sel +: 2]) << (2*j);
    end
    return a;
  endfunction

  function automatic logic [15:0] model_eval(input logic [31:0] x);
    logic [15:0] r;
    r = '0;
    for (int n = 0; n < N_NEURONS; n++) r[2*n +: 2] = model_lut[n][model_addr(n, x)];
    return r;
  endfunction

  // Drives one config cycle while idle and records it in the model.
  task automatic cfg_idle(input bit do_lut, input int ln, input int le, input logic [1:0] ld,
                          input bit do_map, input int mn, input logic [11:0] md);
    lut_we   = do_lut;
    lut_addr = 9'((ln << 6) | le);
    lut_data = ld;
    map_we   = do_map;
    map_addr = 3'(mn);
    map_data = md;
    if (do_lut) model_lut[ln][le] = ld;
    if (do_map) model_map[mn] = md;
    tick;
    lut_we = 1'b0;
    map_we = 1'b0;
  endtask

  task automatic start_vec(input logic [31:0] d, output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick; n++; end
    ok       = in_ready;
    in_valid = 1'b1;
    in_data  = d;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [15:0] r, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin tick; n++; end
    ok = out_valid;
    r  = out_data;
  endtask

  task automatic run_vec(input logic [31:0] d, output logic [15:0] r, output bit ok);
    bit ok1, ok2;
    start_vec(d, ok1);
    wait_out(r, ok2);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    ok = ok1 & ok2;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (cfg_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cfg_ready: got %b want 1", cfg_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    rst_n = 1'b1;
    tick;
    vectors++; if (in_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: in_ready %b busy %b want 1 0", in_ready, busy); end
  endtask

  task automatic test_zero_table;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    tick;
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL eval_entry: in_ready %b busy %b want 0 1", in_ready, busy); end
    for (int c = 1; c <= N_NEURONS; c++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL early_out_valid c%0d: got %b want 0", c, out_valid); end
      tick;
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL latency c%0d: out_valid %b want 1", LAT, out_valid); end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL zero_table: got %h want 0000", out_data); end
    tick;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL ready_return: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_program;
    logic [15:0] r;
    bit ok;
    cfg_idle(1'b0, 0, 0, 2'b00, 1'b1, 3, {4'd7, 4'd4, 4'd0});
    cfg_idle(1'b1, 3, 6'b110101, 2'b11, 1'b0, 0, 12'h000);
    run_vec(32'h0000_C101, r, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL program_timeout: got no result want result"); end
    vectors++; if (r !== 16'h00C0) begin miscompares++; $display("FAIL program_result: got %h want 00c0", r); end
    vectors++; if (r !== model_eval(32'h0000_C101)) begin miscompares++; $display("FAIL program_model: got %h want %h", r, model_eval(32'h0000_C101)); end
  endtask

  task automatic test_backpressure;
    logic [15:0] r, exp2;
    logic [31:0] d2;
    bit ok;
    d2 = $urandom;
    start_vec(32'h0000_C101, ok);
    wait_out(r, ok);
    vectors++; if (!ok || r !== 16'h00C0) begin miscompares++; $display("FAIL bp_first: got %h valid %b want 00c0", r, ok); end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = d2;
      vectors++; if (out_data !== 16'h00C0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold %0d: data %h valid %b in_ready %b want 00c0 1 0", i, out_data, out_valid, in_ready);
      end
      tick;
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_release: in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
    exp2 = model_eval(d2);
    tick;
    in_valid = 1'b0;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL bp_second_accept: busy %b want 1", busy); end
    wait_out(r, ok);
    vectors++; if (!ok || r !== exp2) begin miscompares++; $display("FAIL bp_second: got %h want %h", r, exp2); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_cfg_during_eval;
    logic [15:0] r;
    bit ok;
    start_vec(32'h0000_C101, ok);
    lut_we   = 1'b1;
    lut_addr = {3'd3, 6'b110101};
    lut_data = 2'b00;
    vectors++; if (cfg_ready !== 1'b0) begin miscompares++; $display("FAIL cfg_ready_eval: got %b want 0", cfg_ready); end
    tick;
    lut_we = 1'b0;
    wait_out(r, ok);
    map_we   = 1'b1;
    map_addr = 3'd3;
    map_data = 12'h000;
    tick;
    map_we    = 1'b0;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    vectors++; if (!ok || r !== 16'h00C0) begin miscompares++; $display("FAIL cfg_drop_first: got %h want 00c0", r); end
    run_vec(32'h0000_C101, r, ok);
    vectors++; if (!ok || r !== 16'h00C0) begin miscompares++; $display("FAIL cfg_drop_repeat: got %h want 00c0", r); end
  endtask

  task automatic test_reset_mid_eval;
    logic [15:0] r;
    bit ok;
    start_vec(32'h0000_C101, ok);
    repeat (4) tick;
    rst_n = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
      miscompares++; $display("FAIL midreset_ctrl: out_valid %b busy %b in_ready %b cfg_ready %b want 0 0 1 1", out_valid, busy, in_ready, cfg_ready);
    end
    vectors++; if (out_data !== 16'h0000) begin miscompares++; $display("FAIL midreset_data: got %h want 0000", out_data); end
    tick;
    rst_n = 1'b1;
    tick;
    model_clear();
    run_vec(32'h0000_C101, r, ok);
    vectors++; if (!ok || r !== 16'h0000) begin miscompares++; $display("FAIL midreset_cleared: got %h want 0000", r); end
  endtask

  task automatic test_random;
    logic [15:0] r, e;
    logic [31:0] d;
    bit ok;
    int n;
    for (int i = 0; i < 300; i++) begin
      cfg_idle(1'b1, $urandom_range(0, 7), $urandom_range(0, 63), 2'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0), $urandom_range(0, 7), 12'($urandom));
    end
    for (int v = 0; v < 12; v++) begin
      d = $urandom;
      if (v % 3 == 0) begin
        // Config write in the same cycle as the accept, aimed at an entry this vector uses.
        n = $urandom_range(0, 7);
        lut_we   = 1'b1;
        lut_addr = 9'((n << 6) | model_addr(n, d));
        lut_data = ~model_lut[n][model_addr(n, d)];
        model_lut[n][model_addr(n, d)] = lut_data;
      end
      e = model_eval(d);
      start_vec(d, ok);
      lut_we = 1'b0;
      wait_out(r, ok);
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
      vectors++; if (!ok || r !== e) begin miscompares++; $display("FAIL random_vec %0d: got %h want %h", v, r, e); end
    end
  endtask

  task automatic test_back_to_back;
    int acc_cnt, res_cnt, last_acc;
    bit acc;
    logic [15:0] e;
    acc_cnt   = 0;
    res_cnt   = 0;
    last_acc  = -1;
    in_data   = $urandom;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      acc = 1'b0;
      if (in_ready && out_valid) begin miscompares++; $display("FAIL b2b_overlap %0d: in_ready and out_valid both 1 want exclusive", i); end
      if (out_valid) begin
        res_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++; $display("FAIL b2b_extra %0d: got %h want no result", i, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) begin miscompares++; $display("FAIL b2b_result %0d: got %h want %h", i, out_data, e); end
        end
      end
      if (in_ready) begin
        exp_q.push_back(model_eval(in_data));
        acc = 1'b1;
        if (last_acc >= 0) begin
          vectors++;
          if (i - last_acc !== N_NEURONS + 2) begin miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", i - last_acc, N_NEURONS + 2); end
        end
        last_acc = i;
        acc_cnt++;
      end
      tick;
      if (acc) in_data = $urandom;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    vectors++; if (acc_cnt !== 10) begin miscompares++; $display("FAIL b2b_accepts: got %0d want 10", acc_cnt); end
    vectors++; if (res_cnt !== 10) begin miscompares++; $display("FAIL b2b_results: got %0d want 10", res_cnt); end
    vectors++; if (exp_q.size() !== 0) begin miscompares++; $display("FAIL b2b_pending: got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    lut_we      = 1'b0;
    lut_addr    = '0;
    lut_data    = '0;
    map_we      = 1'b0;
    map_addr    = '0;
    map_data    = '0;
    model_clear();
    tick;
    test_reset();
    test_zero_table();
    test_program();
    test_backpressure();
    test_cfg_during_eval();
    test_reset_mid_eval();
    test_random();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
